// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple block transfer sequencer: walks a 16-bit register list in
// ascending order, issuing one memory access per set bit, then optionally writes back the base.
module ldm_stm_sequencer #(
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start,
   input  logic        load,
   input  logic        increment,
   input  logic        writeback,
   input  logic [15:0] reg_list,
   input  logic [3:0]  base_reg,
   input  logic [31:0] base_addr,
   input  logic [31:0] rf_pa,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  rf_a,
   output logic [3:0]  rf_c,
   output logic        rf_enable,
   output logic [31:0] rf_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] STEP = 32'(ADDR_STEP);

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   state_t      state_r, state_next_s;
   logic        load_r, inc_r, wb_r;
   logic [15:0] list_r, orig_list_r;
   logic [3:0]  base_reg_r;
   logic [31:0] addr_r, final_r;

   logic [31:0] span_s;
   logic [3:0]  cur_s;
   logic [15:0] remaining_s;
   logic        wb_take_s;

   assign span_s      = STEP * {27'd0, popcount16(reg_list)};
   assign cur_s       = lowest_set(list_r);
   assign remaining_s = list_r & ~(16'd1 << cur_s);
   // A load that overwrites the base register wins over the writeback value.
   assign wb_take_s   = wb_r & ~(load_r & orig_list_r[base_reg_r]);

   // State register and latched operation context.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_r     <= IDLE;
         load_r      <= 1'b0;
         inc_r       <= 1'b0;
         wb_r        <= 1'b0;
         list_r      <= 16'd0;
         orig_list_r <= 16'd0;
         base_reg_r  <= 4'd0;
         addr_r      <= 32'd0;
         final_r     <= 32'd0;
      end else begin
         state_r <= state_next_s;
         case (state_r)
            IDLE: begin
               if (start) begin
                  load_r      <= load;
                  inc_r       <= increment;
                  wb_r        <= writeback;
                  list_r      <= reg_list;
                  orig_list_r <= reg_list;
                  base_reg_r  <= base_reg;
                  addr_r      <= increment ? base_addr : base_addr - span_s;
                  final_r     <= increment ? base_addr + span_s : base_addr - span_s;
               end
            end
            XFER: begin
               if (mem_ack) begin
                  list_r <= remaining_s;
                  addr_r <= addr_r + STEP;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode and output drive.
   always_comb begin
      state_next_s = state_r;
      rf_a         = 4'd0;
      rf_c         = 4'd0;
      rf_enable    = 1'b0;
      rf_wdata     = 32'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      done         = 1'b0;
      busy         = (state_r != IDLE);
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = (reg_list != 16'd0) ? XFER : DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         XFER: begin
            mem_req  = 1'b1;
            mem_we   = ~load_r;
            mem_addr = addr_r;
            if (!load_r) begin
               rf_a      = cur_s;
               mem_wdata = rf_pa;
            end else begin
               rf_a      = 4'd0;
            end
            if (mem_ack) begin
               if (load_r) begin
                  rf_enable = 1'b1;
                  rf_c      = cur_s;
                  rf_wdata  = mem_rdata;
               end else begin
                  rf_enable = 1'b0;
               end
               if (remaining_s == 16'd0) begin
                  state_next_s = wb_take_s ? WB : DONE;
               end else begin
                  state_next_s = XFER;
               end
            end else begin
               state_next_s = XFER;
            end
         end
         WB: begin
            rf_enable    = 1'b1;
            rf_c         = base_reg_r;
            rf_wdata     = final_r;
            state_next_s = DONE;
         end
         DONE: begin
            done         = 1'b1;
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   logic unused_s;
   assign unused_s = inc_r;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed operations push expected beats,
// writebacks and done pulses; a negedge monitor pops and compares what the DUT presents.
module tb_ldm_stm_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        start = 1'b0, load = 1'b0, increment = 1'b0, writeback = 1'b0;
   logic [15:0] reg_list = 16'd0;
   logic [3:0]  base_reg = 4'd0;
   logic [31:0] base_addr = 32'd0;
   logic [31:0] rf_pa, mem_rdata;
   logic        mem_ack = 1'b0;
   logic [3:0]  rf_a, rf_c;
   logic        rf_enable, mem_req, mem_we, busy, done;
   logic [31:0] rf_wdata, mem_addr, mem_wdata;

   ldm_stm_sequencer #(.ADDR_STEP(4)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .load(load), .increment(increment),
      .writeback(writeback), .reg_list(reg_list), .base_reg(base_reg), .base_addr(base_addr),
      .rf_pa(rf_pa), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_a(rf_a), .rf_c(rf_c),
      .rf_enable(rf_enable), .rf_wdata(rf_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   // Register file and memory data are simple functions of their selects.
   assign rf_pa     = 32'hD00D_0000 | {28'd0, rf_a};
   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          kind;   // 0 beat, 1 writeback, 2 done
      logic [31:0] addr;
      logic        we;
      logic [3:0]  r;
      logic [31:0] data;
      int          cyc;    // negative: do not check timing
   } ev_t;
   ev_t q[$];

   task automatic push(input int kind, input logic [31:0] addr, input logic we,
                       input logic [3:0] r, input logic [31:0] data, input int c);
      ev_t e;
      e.kind = kind; e.addr = addr; e.we = we; e.r = r; e.data = data; e.cyc = c;
      q.push_back(e);
   endtask

   // Memory responder: acks after wait_cycles stall cycles per beat.
   int wait_cycles = 0;
   int wcnt = 0;
   always @(posedge CLK) begin
      #1;
      if (mem_req) begin
         if (wcnt >= wait_cycles) begin
            mem_ack = 1'b1;
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt = 0;
      end
   end

   // Monitor: compare every presented beat / writeback / done against the queue head.
   always @(negedge CLK) begin
      ev_t e;
      if (mem_req && mem_ack) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("beat_kind", e.kind, 0);
            chk("beat_addr", mem_addr, e.addr);
            chk("beat_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.we) begin
               chk("stm_rf_a", {28'd0, rf_a}, {28'd0, e.r});
               chk("stm_wdata", mem_wdata, e.data);
               chk("stm_rf_en", {31'd0, rf_enable}, 32'd0);
            end else begin
               chk("ldm_rf_en", {31'd0, rf_enable}, 32'd1);
               chk("ldm_rf_c", {28'd0, rf_c}, {28'd0, e.r});
               chk("ldm_wdata", rf_wdata, e.data);
            end
            if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
         end
      end else if (mem_req) begin
         chk("wait_rf_en", {31'd0, rf_enable}, 32'd0);
         if (q.size() > 0 && q[0].kind == 0) begin
            chk("wait_addr", mem_addr, q[0].addr);
            if (q[0].we) chk("wait_wdata", mem_wdata, q[0].data);
         end
      end
      if (rf_enable && !mem_req) begin
         if (q.size() == 0) begin
            chk("unexpected_wb", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("wb_kind", e.kind, 1);
            chk("wb_rf_c", {28'd0, rf_c}, {28'd0, e.r});
            chk("wb_data", rf_wdata, e.data);
            if (e.cyc >= 0) chk("wb_cycle", cyc, e.cyc);
         end
      end
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("done_kind", e.kind, 2);
            chk("done_busy", {31'd0, busy}, 32'd1);
            chk("done_mem_req", {31'd0, mem_req}, 32'd0);
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Issue one start; returns the cycle index at which the DUT is in its first busy cycle.
   task automatic issue(input logic ld, input logic inc, input logic wb, input logic [15:0] lst,
                        input logic [3:0] br, input logic [31:0] base, output int t);
      @(negedge CLK);
      start = 1'b1; load = ld; increment = inc; writeback = wb;
      reg_list = lst; base_reg = br; base_addr = base;
      @(posedge CLK);
      #1;
      t = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge CLK);
         if (done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      @(negedge CLK);
      chk({nm, "_idle_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, "_we"}, {31'd0, mem_we}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd0);
      chk({nm, "_rfen"}, {31'd0, rf_enable}, 32'd0);
      chk({nm, "_addr"}, mem_addr, 32'd0);
      chk({nm, "_wdata"}, mem_wdata, 32'd0);
      chk({nm, "_rfsel"}, {24'd0, rf_a, rf_c}, 32'd0);
      chk({nm, "_rfwd"}, rf_wdata, 32'd0);
   endtask

   task automatic op_stm_basic(input string nm);
      int t;
      issue(1'b0, 1'b1, 1'b1, 16'h0005, 4'd13, 32'h100, t);
      push(0, 32'h100, 1'b1, 4'd0, 32'hD00D_0000, t);
      push(0, 32'h104, 1'b1, 4'd2, 32'hD00D_0002, t + 1);
      push(1, 32'd0, 1'b0, 4'd13, 32'h108, t + 2);
      push(2, 32'd0, 1'b0, 4'd0, 32'd0, t + 3);
      wait_done(nm);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_outputs_zero("reset");
      RESET = 1'b1;
      @(negedge CLK);
      chk_outputs_zero("post_reset");

      op_stm_basic("stm_inc");

      // Descending load: addresses 0x1F8 (R0), 0x1FC (R15); base becomes 0x1F8.
      issue(1'b1, 1'b0, 1'b1, 16'h8001, 4'd13, 32'h200, t);
      push(0, 32'h1F8, 1'b0, 4'd0, 32'h1F8 ^ 32'hA5A5_0000, t);
      push(0, 32'h1FC, 1'b0, 4'd15, 32'h1FC ^ 32'hA5A5_0000, t + 1);
      push(1, 32'd0, 1'b0, 4'd13, 32'h1F8, t + 2);
      push(2, 32'd0, 1'b0, 4'd0, 32'd0, t + 3);
      wait_done("ldm_dec");

      // Base register in the load list: writeback suppressed.
      issue(1'b1, 1'b1, 1'b1, 16'h2002, 4'd13, 32'h300, t);
      push(0, 32'h300, 1'b0, 4'd1, 32'h300 ^ 32'hA5A5_0000, t);
      push(0, 32'h304, 1'b0, 4'd13, 32'h304 ^ 32'hA5A5_0000, t + 1);
      push(2, 32'd0, 1'b0, 4'd0, 32'd0, t + 2);
      wait_done("ldm_base_in_list");

      // Empty list: straight to done, busy only one cycle.
      issue(1'b0, 1'b1, 1'b1, 16'h0000, 4'd3, 32'h500, t);
      push(2, 32'd0, 1'b0, 4'd0, 32'd0, t);
      wait_done("empty_list");

      // Wait states plus a stray start mid-transfer that must be ignored.
      wait_cycles = 3;
      issue(1'b0, 1'b1, 1'b0, 16'h0011, 4'd7, 32'h400, t);
      push(0, 32'h400, 1'b1, 4'd0, 32'hD00D_0000, -1);
      push(0, 32'h404, 1'b1, 4'd4, 32'hD00D_0004, -1);
      push(2, 32'd0, 1'b0, 4'd0, 32'd0, -1);
      repeat (2) @(negedge CLK);
      start = 1'b1; load = 1'b1; increment = 1'b0; writeback = 1'b1;
      reg_list = 16'hFFFF; base_reg = 4'd1; base_addr = 32'h9000;
      @(negedge CLK);
      start = 1'b0;
      wait_done("stm_wait");

      // Reset mid-transfer with the memory stalled.
      wait_cycles = 100;
      issue(1'b0, 1'b1, 1'b1, 16'h00F0, 4'd2, 32'h600, t);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(posedge CLK);
      #1 RESET = 1'b1;
      @(negedge CLK);
      chk_outputs_zero("mid_reset");
      repeat (3) @(negedge CLK);
      chk("mid_reset_still_idle", {31'd0, busy}, 32'd0);
      wait_cycles = 0;
      op_stm_basic("after_reset");

      repeat (3) @(negedge CLK);
      chk("leftover_expect", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
